// File: rtl/fadd_accum.sv
// Sum-reduction controller around an external combinational fadd datapath.
// It feeds {running sum, operand} to fadd, registers the result on each accepted beat, and returns the sum with sticky flags.
module fadd_accum #(
    parameter int exp   = 8,
    parameter int frac  = 23,
    parameter int CNT_W = 16,
    localparam int width = exp + frac + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             round_mode,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [width-1:0] fa_a,
    output logic [width-1:0] fa_b,
    output logic             fa_round_mode,
    input  logic [width-1:0] fa_r,
    input  logic [4:0]       fa_flags,
    output logic             out_valid,
    output logic [width-1:0] out_data,
    output logic [4:0]       out_flags,
    output logic [CNT_W-1:0] out_count,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [width-1:0] acc_q,   acc_d;
    logic [4:0]       flags_q, flags_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q,  mode_d;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        count_d = count_q;
        mode_d  = mode_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    flags_d = '0;
                    count_d = '0;
                    mode_d  = round_mode;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d   = fa_r;
                    flags_d = flags_q | fa_flags;
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A start coinciding with the result handshake chains straight into the next reduction.
                if (out_ready) begin
                    if (start) begin
                        state_d = S_ACCUM;
                        acc_d   = '0;
                        flags_d = '0;
                        count_d = '0;
                        mode_d  = round_mode;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            flags_q <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready      = (state_q == S_ACCUM);
    assign out_valid     = (state_q == S_DONE);
    assign busy          = (state_q == S_ACCUM) || (state_q == S_DONE);
    assign fa_a          = acc_q;
    assign fa_b          = in_data;
    assign fa_round_mode = mode_q;
    assign out_data      = acc_q;
    assign out_flags     = flags_q;
    assign out_count     = count_q;

endmodule

// File: tb/tb_fadd_accum.sv
// Directed bench for fadd_accum; the external fadd is a lookup of hand-computed sums for the operand pairs used here.
module tb_fadd_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, round_mode = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, busy, fa_round_mode;
    logic [31:0] fa_a, fa_b, fa_r, out_data;
    logic [4:0]  fa_flags, out_flags;
    logic [15:0] out_count;

    logic        s_start = 1'b0, s_in_valid = 1'b0, s_in_last = 1'b0, s_out_ready = 1'b0;
    logic [31:0] s_in_data = '0;
    logic        s_in_ready, s_out_valid, s_busy, s_fa_round_mode;
    logic [31:0] s_fa_a, s_fa_b, s_fa_r, s_out_data;
    logic [4:0]  s_fa_flags, s_out_flags;
    logic [1:0]  s_out_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fadd_accum dut (
        .clk(clk), .rst(rst), .start(start), .round_mode(round_mode),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .fa_a(fa_a), .fa_b(fa_b), .fa_round_mode(fa_round_mode), .fa_r(fa_r), .fa_flags(fa_flags),
        .out_valid(out_valid), .out_data(out_data), .out_flags(out_flags), .out_count(out_count),
        .out_ready(out_ready), .busy(busy)
    );

    fadd_accum #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .round_mode(1'b1),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_last(s_in_last), .in_ready(s_in_ready),
        .fa_a(s_fa_a), .fa_b(s_fa_b), .fa_round_mode(s_fa_round_mode), .fa_r(s_fa_r), .fa_flags(s_fa_flags),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_flags(s_out_flags), .out_count(s_out_count),
        .out_ready(s_out_ready), .busy(s_busy)
    );

    // Unknown pairs return an all-ones poison value so an unintended beat corrupts the result visibly.
    function automatic logic [36:0] fadd_lut(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h00000000, 32'h00000000}: return {5'b00000, 32'h00000000};
            {32'h00000000, 32'h3F800000}: return {5'b00000, 32'h3F800000};
            {32'h3F800000, 32'h40000000}: return {5'b00000, 32'h40400000};
            {32'h40400000, 32'h40400000}: return {5'b00000, 32'h40C00000};
            {32'h00000000, 32'h7F7FFFFF}: return {5'b00000, 32'h7F7FFFFF};
            {32'h7F7FFFFF, 32'h7F7FFFFF}: return {5'b00101, 32'h7F800000};
            {32'h00000000, 32'h7F800000}: return {5'b00000, 32'h7F800000};
            {32'h7F800000, 32'hFF800000}: return {5'b10000, 32'h7FC00000};
            {32'h7FC00000, 32'h3F800000}: return {5'b10000, 32'h7FC00000};
            {32'h3F800000, 32'h33800000}: return {5'b00001, 32'h3F800000};
            default:                      return {5'b11111, 32'hFFFFFFFF};
        endcase
    endfunction

    always_comb {fa_flags, fa_r} = fadd_lut(fa_a, fa_b);
    always_comb {s_fa_flags, s_fa_r} = fadd_lut(s_fa_a, s_fa_b);

    task automatic do_start(input logic rm);
        start = 1'b1;
        round_mode = rm;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL %s_done_timeout got out_valid=%b expected 1", name, out_valid);
        else pass_cnt++;
    endtask

    task automatic finish_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total_cnt++;
        if ({in_ready, out_valid, busy, out_data, out_flags, out_count, fa_round_mode} !== '0)
            $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b data=%h flags=%b cnt=%0d expected all 0",
                     in_ready, out_valid, busy, out_data, out_flags, out_count);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (fa_b !== 32'h12345678) $display("FAIL idle_fa_b got %h expected 12345678", fa_b);
        else pass_cnt++;
        total_cnt++;
        if ({in_ready, out_valid, busy} !== 3'b000 || fa_a !== 32'h0 || out_count !== 16'd0)
            $display("FAIL idle_ignores_beat got rdy=%b vld=%b busy=%b acc=%h cnt=%0d expected 0", in_ready, out_valid, busy, fa_a, out_count);
        else pass_cnt++;
        in_valid = 1'b0;
    endtask

    task automatic test_sum(input string name);
        do_start(1'b1);
        total_cnt++;
        if ({in_ready, busy, out_valid} !== 3'b110 || out_count !== 16'd0 || out_flags !== 5'b0 || fa_round_mode !== 1'b1)
            $display("FAIL %s_accum_entry got rdy=%b busy=%b vld=%b cnt=%0d flags=%b mode=%b expected 1 1 0 0 0 1",
                     name, in_ready, busy, out_valid, out_count, out_flags, fa_round_mode);
        else pass_cnt++;
        beat(32'h3F800000, 1'b0);
        beat(32'h40000000, 1'b0);
        beat(32'h40400000, 1'b1);
        wait_done(name);
        total_cnt++;
        if (out_data !== 32'h40C00000 || out_flags !== 5'b00000 || out_count !== 16'd3 || in_ready !== 1'b0)
            $display("FAIL %s_result got data=%h flags=%b cnt=%0d rdy=%b expected 40c00000 00000 3 0", name, out_data, out_flags, out_count, in_ready);
        else pass_cnt++;
        finish_result();
        total_cnt++;
        if ({out_valid, busy, in_ready} !== 3'b000)
            $display("FAIL %s_back_to_idle got vld=%b busy=%b rdy=%b expected 000", name, out_valid, busy, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_start(1'b0);
        total_cnt++;
        if (fa_round_mode !== 1'b0) $display("FAIL ovf_mode got %b expected 0", fa_round_mode);
        else pass_cnt++;
        beat(32'h7F7FFFFF, 1'b0);
        beat(32'h7F7FFFFF, 1'b1);
        wait_done("ovf");
        total_cnt++;
        if (out_data !== 32'h7F800000 || out_flags !== 5'b00101 || out_count !== 16'd2)
            $display("FAIL ovf_result got data=%h flags=%b cnt=%0d expected 7f800000 00101 2", out_data, out_flags, out_count);
        else pass_cnt++;
        finish_result();
    endtask

    task automatic test_nan();
        do_start(1'b1);
        beat(32'h7F800000, 1'b0);
        beat(32'hFF800000, 1'b0);
        total_cnt++;
        if (fa_a !== 32'h7FC00000 || out_flags !== 5'b10000)
            $display("FAIL nan_mid got acc=%h flags=%b expected 7fc00000 10000", fa_a, out_flags);
        else pass_cnt++;
        beat(32'h3F800000, 1'b1);
        wait_done("nan");
        total_cnt++;
        if (out_data !== 32'h7FC00000 || out_flags !== 5'b10000 || out_count !== 16'd3)
            $display("FAIL nan_result got data=%h flags=%b cnt=%0d expected 7fc00000 10000 3", out_data, out_flags, out_count);
        else pass_cnt++;
        finish_result();
    endtask

    task automatic test_tie();
        do_start(1'b1);
        round_mode = 1'b0;
        beat(32'h3F800000, 1'b0);
        total_cnt++;
        if (fa_round_mode !== 1'b1) $display("FAIL tie_mode_latched got %b expected 1", fa_round_mode);
        else pass_cnt++;
        beat(32'h33800000, 1'b1);
        wait_done("tie");
        total_cnt++;
        if (out_data !== 32'h3F800000 || out_flags !== 5'b00001 || out_count !== 16'd2)
            $display("FAIL tie_result got data=%h flags=%b cnt=%0d expected 3f800000 00001 2", out_data, out_flags, out_count);
        else pass_cnt++;
        finish_result();
    endtask

    task automatic test_back_to_back();
        do_start(1'b0);
        beat(32'h7F7FFFFF, 1'b0);
        in_data = 32'h12345678;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (out_count !== 16'd1 || fa_a !== 32'h7F7FFFFF)
            $display("FAIL b2b_gap got cnt=%0d acc=%h expected 1 7f7fffff", out_count, fa_a);
        else pass_cnt++;
        beat(32'h7F7FFFFF, 1'b1);
        wait_done("b2b");
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            in_valid = (i == 3);
            in_data = 32'h3F800000;
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== 32'h7F800000 || out_flags !== 5'b00101 || out_count !== 16'd2)
                $display("FAIL b2b_hold%0d got vld=%b data=%h flags=%b cnt=%0d expected 1 7f800000 00101 2",
                         i, out_valid, out_data, out_flags, out_count);
            else pass_cnt++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        round_mode = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready, busy} !== 3'b011 || out_flags !== 5'b0 || out_count !== 16'd0 || fa_a !== 32'h0)
            $display("FAIL b2b_restart got vld=%b rdy=%b busy=%b flags=%b cnt=%0d acc=%h expected 0 1 1 0 0 0",
                     out_valid, in_ready, busy, out_flags, out_count, fa_a);
        else pass_cnt++;
        beat(32'h3F800000, 1'b0);
        beat(32'h40000000, 1'b0);
        beat(32'h40400000, 1'b1);
        wait_done("b2b2");
        total_cnt++;
        if (out_data !== 32'h40C00000 || out_flags !== 5'b00000 || out_count !== 16'd3)
            $display("FAIL b2b_second got data=%h flags=%b cnt=%0d expected 40c00000 00000 3", out_data, out_flags, out_count);
        else pass_cnt++;
        finish_result();
    endtask

    task automatic test_mid_reset();
        do_start(1'b1);
        beat(32'h3F800000, 1'b0);
        beat(32'h40000000, 1'b0);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== 32'h0 || out_flags !== 5'b0 || out_count !== 16'd0 || fa_round_mode !== 1'b0)
            $display("FAIL midrst_outputs got rdy=%b vld=%b busy=%b data=%h flags=%b cnt=%0d expected all 0",
                     in_ready, out_valid, busy, out_data, out_flags, out_count);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_sum("midrst");
    endtask

    task automatic test_count_saturate();
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_in_data = 32'h0;
        for (int i = 0; i < 5; i++) begin
            s_in_valid = 1'b1;
            s_in_last = (i == 4);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        s_in_last = 1'b0;
        total_cnt++;
        if (s_out_valid !== 1'b1 || s_out_count !== 2'd3 || s_out_data !== 32'h0 || s_out_flags !== 5'b0)
            $display("FAIL sat_count got vld=%b cnt=%0d data=%h flags=%b expected 1 3 0 0", s_out_valid, s_out_count, s_out_data, s_out_flags);
        else pass_cnt++;
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        total_cnt++;
        if (s_busy !== 1'b0) $display("FAIL sat_idle got busy=%b expected 0", s_busy);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sum("sum");
        test_overflow();
        test_nan();
        test_tie();
        test_back_to_back();
        test_mid_reset();
        test_count_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
